// File: rtl/pipelined_counter_checker.sv
`default_nettype none
// ============================================================================
// Module      : pipelined_counter_checker
// Description : Checks that a valid-qualified counter stream increments by one
//               (mod 2^WIDTH); reports lock, mismatches and wrap-around.
// Revision    : 1.0
// ============================================================================
module pipelined_counter_checker #(
    parameter int WIDTH     = 16,
    parameter int LOCK_CNT  = 2,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 locked,
    output logic                 err_pulse,
    output logic                 err_sticky,
    output logic [ERR_CNT_W-1:0] err_count,
    output logic [WIDTH-1:0]     exp_data,
    output logic                 wrap_pulse
);

    localparam int                    GOOD_W    = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0]     GOOD_LOCK = GOOD_W'(LOCK_CNT);
    localparam logic [ERR_CNT_W-1:0]  ERR_MAX   = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    state_t             state;
    logic [GOOD_W-1:0]  good;

    logic               w_match;
    logic [WIDTH-1:0]   w_next_exp;
    logic [GOOD_W-1:0]  w_good_inc;

    assign w_match    = (in_data == exp_data);
    assign w_next_exp = in_data + WIDTH'(1);
    assign w_good_inc = good + GOOD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            good       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            exp_data   <= '0;
            wrap_pulse <= 1'b0;
        end else if (clr) begin
            // clr wins over a coincident sample; that sample is discarded
            state      <= ST_IDLE;
            good       <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            exp_data   <= '0;
            wrap_pulse <= 1'b0;
        end else begin
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            if (in_valid) begin
                // Every sample re-seeds the expectation, matching or not
                exp_data <= w_next_exp;
                case (state)
                    ST_IDLE: begin
                        good  <= '0;
                        state <= ST_ACQ;
                    end
                    ST_ACQ: begin
                        if (w_match) begin
                            good <= w_good_inc;
                            if (w_good_inc == GOOD_LOCK) begin
                                state  <= ST_LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            good <= '0;
                        end
                    end
                    ST_LOCKED: begin
                        if (w_match) begin
                            wrap_pulse <= (in_data == '0);
                        end else begin
                            err_pulse  <= 1'b1;
                            err_sticky <= 1'b1;
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + ERR_CNT_W'(1);
                            end
                            good   <= '0;
                            state  <= ST_ACQ;
                            locked <= 1'b0;
                        end
                    end
                    default: begin
                        good   <= '0;
                        state  <= ST_IDLE;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_counter_checker.sv
`default_nettype none
// Testbench for pipelined_counter_checker: directed stimulus with a queued
// expectation per cycle, compared by an independent monitor process.
module tb_pipelined_counter_checker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        locked, err_pulse, err_sticky, wrap_pulse;
    logic [7:0]  err_count;
    logic [15:0] exp_data;

    typedef struct packed {
        logic        lk;
        logic        ep;
        logic        es;
        logic [7:0]  ec;
        logic [15:0] ed;
        logic        wp;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    checks = 0;
    int    errors = 0;
    logic  chk_tgl = 1'b0;

    pipelined_counter_checker #(.WIDTH(16), .LOCK_CNT(2), .ERR_CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky),
        .err_count  (err_count),
        .exp_data   (exp_data),
        .wrap_pulse (wrap_pulse)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per clock edge (or per forced async check)
    initial begin
        obs_t  e, a;
        string nm;
        forever begin
            @(posedge clk or chk_tgl);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                a  = '{lk: locked, ep: err_pulse, es: err_sticky,
                       ec: err_count, ed: exp_data, wp: wrap_pulse};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s: got lk=%b ep=%b es=%b ec=%0d ed=%h wp=%b, want lk=%b ep=%b es=%b ec=%0d ed=%h wp=%b",
                             nm, a.lk, a.ep, a.es, a.ec, a.ed, a.wp,
                             e.lk, e.ep, e.es, e.ec, e.ed, e.wp);
                end
            end
        end
    end

    task automatic push(input logic lk, ep, es, input logic [7:0] ec,
                        input logic [15:0] ed, input logic wp, input string nm);
        exp_q.push_back('{lk: lk, ep: ep, es: es, ec: ec, ed: ed, wp: wp});
        name_q.push_back(nm);
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic c,
                        input logic lk, ep, es, input logic [7:0] ec,
                        input logic [15:0] ed, input logic wp, input string nm);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        clr      = c;
        push(lk, ep, es, ec, ed, wp, nm);
    endtask

    initial begin
        logic [15:0] e_base;
        logic [7:0]  ec_exp;

        // Reset state, held over one idle cycle
        @(negedge clk);
        rst_n = 1'b1;
        push(0, 0, 0, 8'd0, 16'h0000, 0, "reset");

        // Lock: 0,1,2,3
        step(1, 16'd0, 0, 0, 0, 0, 8'd0, 16'd1, 0, "lock_s0");
        step(1, 16'd1, 0, 0, 0, 0, 8'd0, 16'd2, 0, "lock_s1");
        step(1, 16'd2, 0, 1, 0, 0, 8'd0, 16'd3, 0, "lock_s2");
        step(1, 16'd3, 0, 1, 0, 0, 8'd0, 16'd4, 0, "lock_s3");

        // Mismatch 5, then 7 (no error while acquiring), relock on 8,9
        step(1, 16'd5, 0, 0, 1, 1, 8'd1, 16'd6,  0, "mis_5");
        step(1, 16'd7, 0, 0, 0, 1, 8'd1, 16'd8,  0, "mis_7");
        step(1, 16'd8, 0, 0, 0, 1, 8'd1, 16'd9,  0, "relock_8");
        step(1, 16'd9, 0, 1, 0, 1, 8'd1, 16'd10, 0, "relock_9");

        // Gaps keep lock
        step(0, 16'd99, 0, 1, 0, 1, 8'd1, 16'd10, 0, "gap_a");
        step(1, 16'd10, 0, 1, 0, 1, 8'd1, 16'd11, 0, "gap_10");
        step(0, 16'd0,  0, 1, 0, 1, 8'd1, 16'd11, 0, "gap_b");
        step(1, 16'd11, 0, 1, 0, 1, 8'd1, 16'd12, 0, "gap_11");

        // clr with a valid sample: sample dropped, everything cleared
        step(1, 16'd42, 1, 0, 0, 0, 8'd0, 16'd0, 0, "clr_42");

        // Wrap while locked
        step(1, 16'hFFFC, 0, 0, 0, 0, 8'd0, 16'hFFFD, 0, "wrap_fffc");
        step(1, 16'hFFFD, 0, 0, 0, 0, 8'd0, 16'hFFFE, 0, "wrap_fffd");
        step(1, 16'hFFFE, 0, 1, 0, 0, 8'd0, 16'hFFFF, 0, "wrap_fffe");
        step(1, 16'hFFFF, 0, 1, 0, 0, 8'd0, 16'h0000, 0, "wrap_ffff");
        step(1, 16'h0000, 0, 1, 0, 0, 8'd0, 16'h0001, 1, "wrap_0000");
        step(1, 16'h0001, 0, 1, 0, 0, 8'd0, 16'h0002, 0, "wrap_0001");

        // Async reset between clocks: outputs zero immediately
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b0;
        push(0, 0, 0, 8'd0, 16'h0000, 0, "async_rst");
        chk_tgl = ~chk_tgl;
        #2;
        rst_n = 1'b1;
        push(0, 0, 0, 8'd0, 16'h0000, 0, "post_rst_idle");

        // Relock needs three samples
        step(1, 16'd5, 0, 0, 0, 0, 8'd0, 16'd6, 0, "rst_relock_5");
        step(1, 16'd6, 0, 0, 0, 0, 8'd0, 16'd7, 0, "rst_relock_6");
        step(1, 16'd7, 0, 1, 0, 0, 8'd0, 16'd8, 0, "rst_relock_7");

        // 300 forced mismatches, relocking each time; count saturates at 255
        e_base = 16'd8;
        for (int i = 0; i < 300; i++) begin
            ec_exp = (i + 1 > 255) ? 8'd255 : 8'((i + 1));
            step(1, e_base + 16'd100, 0, 0, 1, 1, ec_exp, e_base + 16'd101, 0, "sat_mis");
            step(1, e_base + 16'd101, 0, 0, 0, 1, ec_exp, e_base + 16'd102, 0, "sat_acq");
            step(1, e_base + 16'd102, 0, 1, 0, 1, ec_exp, e_base + 16'd103, 0, "sat_lock");
            e_base = e_base + 16'd103;
        end
        step(0, 16'd0, 0, 1, 0, 1, 8'd255, e_base, 0, "sat_hold");

        // Final clr
        step(0, 16'd0, 1, 0, 0, 0, 8'd0, 16'd0, 0, "final_clr");
        step(0, 16'd0, 0, 0, 0, 0, 8'd0, 16'd0, 0, "final_idle");

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
